// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared defaults, write-request type and port-priority helper for
//           the multiport register file.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int NWR_DEF   = 2;
    localparam int NRD_DEF   = 2;
    localparam int COUNT_W   = 8;

    // Requests are carried at fixed maximum widths so one type serves every
    // parameterisation; unused write ports are tied off with we=0.
    localparam int MAX_PORTS  = 4;
    localparam int REQ_ADDR_W = 16;
    localparam int REQ_DATA_W = 64;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;

    // Highest-index enabled port addressing the entry wins; -1 means no writer.
    function automatic int winning_port(input wr_req_t [MAX_PORTS-1:0] req,
                                        input int                      entry);
        int win;
        win = -1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (req[i].we && (req[i].addr == REQ_ADDR_W'(entry))) begin
                win = i;
            end
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiport_regfile_write_arbiter.sv
// ============================================================================
// Module  : write_arbiter
// Purpose : Per-entry write resolution: enable, winning data and collision.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module write_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ENTRY = 0
) (
    input  wr_req_t [MAX_PORTS-1:0] req_i,
    output logic                    en_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    collision_o
);

    int         win;
    logic [2:0] hits;

    always_comb begin
        win  = winning_port(req_i, ENTRY);
        hits = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (req_i[i].we && (req_i[i].addr == REQ_ADDR_W'(ENTRY))) begin
                hits = hits + 3'd1;
            end
        end
        en_o        = (win >= 0);
        data_o      = en_o ? WIDTH'(req_i[2'(win)].data) : '0;
        collision_o = (hits > 3'd1);
    end

endmodule

`default_nettype wire

// File: rtl/multiport_regfile.sv
// ============================================================================
// Module  : multiport_regfile
// Purpose : NWR-write / NRD-read flip-flop register file with registered
//           reads, highest-port-wins writes and a saturating collision count.
//           Define REGFILE_BYPASS_EN for write-first reads (default read-first).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multiport_regfile
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NWR    = NWR_DEF,
    parameter  int NRD    = NRD_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*WIDTH-1:0]  wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*WIDTH-1:0]  rdata,
    output logic                  collision,
    input  logic                  clr_count,
    output logic [COUNT_W-1:0]    collision_count
);

    wr_req_t [MAX_PORTS-1:0] req;
    logic [DEPTH-1:0]        wen;
    logic [DEPTH-1:0]        ent_coll;
    logic [WIDTH-1:0]        wsel   [DEPTH];
    logic [WIDTH-1:0]        mem_q  [DEPTH];
    logic [WIDTH-1:0]        mem_d  [DEPTH];
    logic [WIDTH-1:0]        rd_src [DEPTH];
    logic [NRD*WIDTH-1:0]    rdata_q, rdata_d;
    logic                    collision_q, collision_d;
    logic [COUNT_W-1:0]      count_q, count_d;

    always_comb begin
        req = '0;
        for (int i = 0; i < NWR; i++) begin
            req[i].we   = we[i];
            req[i].addr = REQ_ADDR_W'(waddr[i*ADDR_W +: ADDR_W]);
            req[i].data = REQ_DATA_W'(wdata[i*WIDTH +: WIDTH]);
        end
    end

    // Out-of-range addresses match no entry, so they neither write nor collide.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        write_arbiter #(
            .WIDTH (WIDTH),
            .ENTRY (e)
        ) u_arb (
            .req_i       (req),
            .en_o        (wen[e]),
            .data_o      (wsel[e]),
            .collision_o (ent_coll[e])
        );
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = wen[e] ? wsel[e] : mem_q[e];
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_src = mem_d;
`else
    assign rd_src = mem_q;
`endif

    always_comb begin
        rdata_d = '0;
        for (int j = 0; j < NRD; j++) begin
            if (int'(raddr[j*ADDR_W +: ADDR_W]) < DEPTH) begin
                rdata_d[j*WIDTH +: WIDTH] = rd_src[raddr[j*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_comb begin
        collision_d = |ent_coll;
        count_d     = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (collision_d && (count_q != '1)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            rdata_q     <= '0;
            collision_q <= 1'b0;
            count_q     <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
            rdata_q     <= rdata_d;
            collision_q <= collision_d;
            count_q     <= count_d;
        end
    end

    assign rdata           = rdata_q;
    assign collision       = collision_q;
    assign collision_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multiport_regfile.sv
// ============================================================================
// Module  : tb_multiport_regfile
// Purpose : Self-checking bench driving an 8-entry and a 6-entry register file
//           from shared inputs against an array-based reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_multiport_regfile;

    localparam int W   = 4;
    localparam int NWR = 2;
    localparam int NRD = 2;
    localparam int AW  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NWR-1:0]     we;
    logic [NWR*AW-1:0]  waddr;
    logic [NWR*W-1:0]   wdata;
    logic [NRD*AW-1:0]  raddr;
    logic               clr_count;
    logic [NRD*W-1:0]   rdata8, rdata6;
    logic               coll8, coll6;
    logic [7:0]         cnt8, cnt6;

    int checks   = 0;
    int failures = 0;

    // Reference state: index 0 models the 8-entry file, index 1 the 6-entry one.
    int unsigned m_mem [2][8];
    int unsigned m_rd  [2][NRD];
    bit          m_col [2];
    int unsigned m_cnt [2];
    int unsigned depth_of [2] = '{8, 6};

    always #5 clk = ~clk;

    multiport_regfile #(.WIDTH(W), .DEPTH(8), .NWR(NWR), .NRD(NRD)) dut8 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata8), .collision(coll8),
        .clr_count(clr_count), .collision_count(cnt8)
    );

    multiport_regfile #(.WIDTH(W), .DEPTH(6), .NWR(NWR), .NRD(NRD)) dut6 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata6), .collision(coll6),
        .clr_count(clr_count), .collision_count(cnt6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 8; e++) m_mem[d][e] = 0;
            for (int j = 0; j < NRD; j++) m_rd[d][j] = 0;
            m_col[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    // Ports are applied in ascending order so the highest-index writer lands last.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int unsigned old [8];
            int unsigned nw  [8];
            bit          hit;
            for (int e = 0; e < 8; e++) begin
                old[e] = m_mem[d][e];
                nw[e]  = 0;
            end
            for (int i = 0; i < NWR; i++) begin
                int unsigned a;
                a = int'(waddr[i*AW +: AW]);
                if (we[i] && a < depth_of[d]) begin
                    m_mem[d][a] = int'(wdata[i*W +: W]);
                    nw[a]++;
                end
            end
            hit = 0;
            for (int e = 0; e < 8; e++) if (nw[e] > 1) hit = 1;
            for (int j = 0; j < NRD; j++) begin
                int unsigned a;
                a = int'(raddr[j*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
                m_rd[d][j] = (a < depth_of[d]) ? m_mem[d][a] : 0;
`else
                m_rd[d][j] = (a < depth_of[d]) ? old[a] : 0;
`endif
            end
            m_col[d] = hit;
            if (clr_count)                 m_cnt[d] = 0;
            else if (hit && m_cnt[d] < 255) m_cnt[d]++;
        end
    endtask

    task automatic compare_all(input string ph);
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("%s.d8.rdata%0d", ph, j), 32'(rdata8[j*W +: W]), m_rd[0][j]);
            check($sformatf("%s.d6.rdata%0d", ph, j), 32'(rdata6[j*W +: W]), m_rd[1][j]);
        end
        check({ph, ".d8.coll"}, 32'(coll8), 32'(m_col[0]));
        check({ph, ".d6.coll"}, 32'(coll6), 32'(m_col[1]));
        check({ph, ".d8.cnt"},  32'(cnt8),  m_cnt[0]);
        check({ph, ".d6.cnt"},  32'(cnt6),  m_cnt[1]);
    endtask

    task automatic step(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic drive(input logic [1:0] we_v, input int a0, input int d0,
                         input int a1, input int d1, input int r0, input int r1,
                         input logic clr);
        we        = we_v;
        waddr     = {AW'(a1), AW'(a0)};
        wdata     = {W'(d1), W'(d0)};
        raddr     = {AW'(r1), AW'(r0)};
        clr_count = clr;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
        #2;
        check("por.rdata8", 32'(rdata8), 32'h0);
        check("por.coll8",  32'(coll8),  32'h0);
        check("por.cnt8",   32'(cnt8),   32'h0);
        release_reset();

        // Single write to addr 3, then read it back.
        drive(2'b01, 3, 4'hA, 0, 0, 0, 0, 1'b0);
        step("wr3");
        drive(2'b00, 0, 0, 0, 0, 3, 3, 1'b0);
        step("rd3");
        check("rd3.value", 32'(rdata8[W-1:0]), 32'hA);
        check("rd3.nocoll", 32'(coll8), 32'h0);

        // Both ports hit addr 6: port1 wins and a single collision is flagged.
        drive(2'b11, 6, 4'h5, 6, 4'hC, 0, 0, 1'b0);
        step("col6");
        check("col6.pulse", 32'(coll8), 32'h1);
        check("col6.cnt",   32'(cnt8),  32'h1);
        drive(2'b00, 0, 0, 0, 0, 6, 6, 1'b0);
        step("col6rd");
        check("col6.mem",   32'(rdata8[W-1:0]), 32'hC);
        check("col6.drop",  32'(coll8), 32'h0);

        // Addr 7: valid on the 8-entry file, out of range on the 6-entry one.
        drive(2'b11, 7, 4'h3, 7, 4'h4, 7, 5, 1'b0);
        step("oor_wr");
        check("oor.d6.nocoll", 32'(coll6), 32'h0);
        check("oor.d8.coll",   32'(coll8), 32'h1);
        drive(2'b00, 0, 0, 0, 0, 7, 7, 1'b0);
        step("oor_rd");
        check("oor.d6.rdata", 32'(rdata6), 32'h0);
        check("oor.d8.rdata", 32'(rdata8[W-1:0]), 32'h4);

        // Same-cycle read and write of addr 2.
        drive(2'b01, 2, 4'h1, 0, 0, 0, 0, 1'b0);
        step("rw_pre");
        drive(2'b01, 2, 4'h9, 0, 0, 2, 2, 1'b0);
        step("rw");
`ifdef REGFILE_BYPASS_EN
        check("rw.value", 32'(rdata8[W-1:0]), 32'h9);
`else
        check("rw.value", 32'(rdata8[W-1:0]), 32'h1);
`endif
        drive(2'b00, 0, 0, 0, 0, 2, 2, 1'b0);
        step("rw_post");
        check("rw.later", 32'(rdata8[W-1:0]), 32'h9);

        // Saturation, then clear wins over a simultaneous collision.
        for (int k = 0; k < 300; k++) begin
            drive(2'b11, k % 6, k, k % 6, k + 1, k % 8, (k + 3) % 8, 1'b0);
            step("sat");
        end
        check("sat.cnt8", 32'(cnt8), 32'd255);
        check("sat.cnt6", 32'(cnt6), 32'd255);
        drive(2'b11, 1, 4'h2, 1, 4'h3, 0, 0, 1'b1);
        step("clr");
        check("clr.cnt8", 32'(cnt8),  32'h0);
        check("clr.coll", 32'(coll8), 32'h1);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(2'($urandom), $urandom_range(0, 7), $urandom, $urandom_range(0, 7),
                  $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 15) == 0));
            step("rnd");
        end

        // Reset in mid-cycle and mid-write clears everything at once.
        drive(2'b11, 4, 4'hF, 5, 4'hE, 4, 5, 1'b0);
        step("pre_rst");
        drive(2'b11, 4, 4'h7, 4, 4'h8, 4, 5, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst.rdata8", 32'(rdata8), 32'h0);
        check("rst.rdata6", 32'(rdata6), 32'h0);
        check("rst.coll8",  32'(coll8),  32'h0);
        check("rst.cnt8",   32'(cnt8),   32'h0);
        release_reset();

        // First edge after release writes; the following read sees reset contents elsewhere.
        drive(2'b01, 4, 4'h6, 0, 0, 5, 4, 1'b0);
        step("post_rst_wr");
        drive(2'b00, 0, 0, 0, 0, 4, 5, 1'b0);
        step("post_rst_rd");
        check("post.rd4", 32'(rdata8[W-1:0]), 32'h6);
        check("post.rd5", 32'(rdata8[2*W-1:W]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
